// File: rtl/alu_exec_pkg.sv
// Shared constants for the execute stage: ALU op codes, RV32 opcodes, operand-B selects.
// Purely declarative; no latency or flow control applies.
// Optional M-extension codes (16-23) are only decoded when RV32M_EN is defined.
package alu_exec_pkg;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_AND    = 5'd2;
    localparam logic [4:0] ALU_OR     = 5'd3;
    localparam logic [4:0] ALU_XOR    = 5'd4;
    localparam logic [4:0] ALU_SLL    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_SLT    = 5'd8;
    localparam logic [4:0] ALU_SLTU   = 5'd9;
    localparam logic [4:0] ALU_PASSB  = 5'd10;
    localparam logic [4:0] ALU_ADDCLR = 5'd11;
    localparam logic [4:0] ALU_MUL    = 5'd16;
    localparam logic [4:0] ALU_MULH   = 5'd17;
    localparam logic [4:0] ALU_MULHSU = 5'd18;
    localparam logic [4:0] ALU_MULHU  = 5'd19;
    localparam logic [4:0] ALU_DIV    = 5'd20;
    localparam logic [4:0] ALU_DIVU   = 5'd21;
    localparam logic [4:0] ALU_REM    = 5'd22;
    localparam logic [4:0] ALU_REMU   = 5'd23;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] BSEL_REG  = 2'd0;
    localparam logic [1:0] BSEL_IMM  = 2'd1;
    localparam logic [1:0] BSEL_FOUR = 2'd2;
    localparam logic [1:0] BSEL_ZERO = 2'd3;

endpackage

// File: rtl/imm_decode.sv
// Decodes the sign-extended RV32 immediate from the instruction word.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inst continuously.
module imm_decode
    import alu_exec_pkg::*;
(
    input  logic [31:0] inst,
    output logic [31:0] imm
);

    always_comb begin
        imm = 32'd0;
        case (inst[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:
                imm = {{20{inst[31]}}, inst[31:20]};
            OP_STORE:
                imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OP_BRANCH:
                imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {inst[31:12], 12'd0};
            OP_JAL:
                imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:
                imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: immediate decode, operand-B mux, 32-bit ALU, compare flags, registered result.
// Latency: everything combinational except alu_out (one sysclk edge); no backpressure.
// Defining RV32M_EN adds single-cycle multiply/divide on op codes 16-23.
module alu_exec_unit
    import alu_exec_pkg::*;
(
    input  logic        sysclk,
    input  logic        reset,
    input  logic [31:0] inst,
    input  logic [31:0] src_a,
    input  logic [31:0] reg_b,
    input  logic [1:0]  b_sel,
    input  logic [4:0]  alu_op,
    output logic [31:0] imm,
    output logic [31:0] alu_result,
    output logic [31:0] alu_out,
    output logic        eq,
    output logic        gt,
    output logic        gtu
);

    logic [31:0] b_op;
    logic [31:0] sum;

    imm_decode u_imm_decode (
        .inst (inst),
        .imm  (imm)
    );

    always_comb begin
        b_op = 32'd0;
        case (b_sel)
            BSEL_REG:  b_op = reg_b;
            BSEL_IMM:  b_op = imm;
            BSEL_FOUR: b_op = 32'd4;
            BSEL_ZERO: b_op = 32'd0;
            default:   b_op = 32'd0;
        endcase
    end

    assign sum = src_a + b_op;
    assign eq  = (src_a == b_op);
    assign gt  = ($signed(src_a) > $signed(b_op));
    assign gtu = (src_a > b_op);

`ifdef RV32M_EN
    logic [63:0] mul_ss;
    logic [63:0] mul_su;
    logic [63:0] mul_uu;
    logic        div_zero;
    logic        div_ovf;
    logic        unused_mul;

    assign mul_ss   = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{b_op[31]}}, b_op});
    assign mul_su   = $signed({{32{src_a[31]}}, src_a}) * $signed({32'd0, b_op});
    assign mul_uu   = {32'd0, src_a} * {32'd0, b_op};
    assign div_zero = (b_op == 32'd0);
    // Most-negative / -1 overflows the signed quotient; handled explicitly.
    assign div_ovf  = (src_a == 32'h8000_0000) && (b_op == 32'hFFFF_FFFF);
    assign unused_mul = ^{mul_su[31:0], mul_uu[31:0]};
`endif

    always_comb begin
        alu_result = 32'd0;
        case (alu_op)
            ALU_ADD:    alu_result = sum;
            ALU_SUB:    alu_result = src_a - b_op;
            ALU_AND:    alu_result = src_a & b_op;
            ALU_OR:     alu_result = src_a | b_op;
            ALU_XOR:    alu_result = src_a ^ b_op;
            ALU_SLL:    alu_result = src_a << b_op[4:0];
            ALU_SRL:    alu_result = src_a >> b_op[4:0];
            ALU_SRA:    alu_result = $unsigned($signed(src_a) >>> b_op[4:0]);
            ALU_SLT:    alu_result = {31'd0, $signed(src_a) < $signed(b_op)};
            ALU_SLTU:   alu_result = {31'd0, src_a < b_op};
            ALU_PASSB:  alu_result = b_op;
            ALU_ADDCLR: alu_result = {sum[31:1], 1'b0};
`ifdef RV32M_EN
            ALU_MUL:    alu_result = mul_ss[31:0];
            ALU_MULH:   alu_result = mul_ss[63:32];
            ALU_MULHSU: alu_result = mul_su[63:32];
            ALU_MULHU:  alu_result = mul_uu[63:32];
            ALU_DIV:    alu_result = div_zero ? 32'hFFFF_FFFF :
                                     div_ovf  ? 32'h8000_0000 :
                                     $unsigned($signed(src_a) / $signed(b_op));
            ALU_DIVU:   alu_result = div_zero ? 32'hFFFF_FFFF : src_a / b_op;
            ALU_REM:    alu_result = div_zero ? src_a :
                                     div_ovf  ? 32'd0 :
                                     $unsigned($signed(src_a) % $signed(b_op));
            ALU_REMU:   alu_result = div_zero ? src_a : src_a % b_op;
`endif
            default:    alu_result = 32'd0;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            alu_out <= 32'd0;
        end else begin
            alu_out <= alu_result;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit: stimulus pushes expectations, a negedge monitor pops and checks.
// M-extension vectors are included only when RV32M_EN is defined.
module tb_alu_exec_unit;
    import alu_exec_pkg::*;

    localparam int SIG_IMM = 0, SIG_RES = 1, SIG_OUT = 2, SIG_EQ = 3, SIG_GT = 4, SIG_GTU = 5;

    logic        sysclk = 1'b0;
    logic        reset;
    logic [31:0] inst, src_a, reg_b;
    logic [1:0]  b_sel;
    logic [4:0]  alu_op;
    logic [31:0] imm, alu_result, alu_out;
    logic        eq, gt, gtu;

    alu_exec_unit dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .inst       (inst),
        .src_a      (src_a),
        .reg_b      (reg_b),
        .b_sel      (b_sel),
        .alu_op     (alu_op),
        .imm        (imm),
        .alu_result (alu_result),
        .alu_out    (alu_out),
        .eq         (eq),
        .gt         (gt),
        .gtu        (gtu)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        string       name;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic expect_val(input string name, input int sig, input logic [31:0] e);
        exp_t it;
        it.name = name;
        it.sig  = sig;
        it.exp  = e;
        sb_q.push_back(it);
    endtask

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            SIG_IMM: return imm;
            SIG_RES: return alu_result;
            SIG_OUT: return alu_out;
            SIG_EQ:  return {31'd0, eq};
            SIG_GT:  return {31'd0, gt};
            default: return {31'd0, gtu};
        endcase
    endfunction

    // Monitor: outputs are settled half a cycle after the driver updates inputs.
    always @(negedge sysclk) begin
        exp_t        it;
        logic [31:0] act;
        while (sb_q.size() > 0) begin
            it  = sb_q.pop_front();
            act = observe(it.sig);
            n_checks++;
            if (act !== it.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
            end
        end
    end

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] bs, input logic [4:0] op);
        inst   = i;
        src_a  = a;
        reg_b  = b;
        b_sel  = bs;
        alu_op = op;
    endtask

    initial begin
        reset = 1'b1;
        drive(32'd0, 32'd2, 32'd3, BSEL_REG, ALU_ADD);
        step();
        expect_val("reset_alu_out", SIG_OUT, 32'd0);
        expect_val("comb_during_reset", SIG_RES, 32'd5);
        step();
        reset = 1'b0;

        // Immediate decode; b_sel=IMM with PASSB also routes imm through the ALU.
        drive(32'hFFF0_0093, 32'd0, 32'd0, BSEL_IMM, ALU_PASSB);
        expect_val("imm_addi", SIG_IMM, 32'hFFFF_FFFF);
        expect_val("passb_addi", SIG_RES, 32'hFFFF_FFFF);
        step();
        drive(32'hFE00_0EE3, 32'd0, 32'd0, BSEL_IMM, ALU_PASSB);
        expect_val("imm_beq", SIG_IMM, 32'hFFFF_FFFC);
        step();
        drive(32'h1234_50B7, 32'd0, 32'd0, BSEL_IMM, ALU_PASSB);
        expect_val("imm_lui", SIG_IMM, 32'h1234_5000);
        expect_val("passb_lui", SIG_RES, 32'h1234_5000);
        step();
        drive(32'h0000_0033, 32'd0, 32'd0, BSEL_IMM, ALU_PASSB);
        expect_val("imm_rtype_zero", SIG_IMM, 32'd0);
        step();

        drive(32'd0, 32'h7FFF_FFFF, 32'd1, BSEL_REG, ALU_ADD);
        expect_val("add_wrap", SIG_RES, 32'h8000_0000);
        step();
        drive(32'd0, 32'h8000_0000, 32'd4, BSEL_REG, ALU_SRA);
        expect_val("sra", SIG_RES, 32'hF800_0000);
        step();
        alu_op = ALU_SRL;
        expect_val("srl", SIG_RES, 32'h0800_0000);
        step();
        drive(32'd0, 32'h8000_0000, 32'd33, BSEL_REG, ALU_SLL);
        expect_val("sll_shamt5", SIG_RES, 32'd0);
        step();
        drive(32'd0, 32'h0000_0010, 32'd3, BSEL_REG, ALU_SUB);
        expect_val("sub", SIG_RES, 32'h0000_000D);
        step();
        drive(32'd0, 32'hF0F0_00FF, 32'h0FF0_0F0F, BSEL_REG, ALU_XOR);
        expect_val("xor", SIG_RES, 32'hFF00_0FF0);
        step();
        alu_op = ALU_AND;
        expect_val("and", SIG_RES, 32'h00F0_000F);
        step();
        alu_op = ALU_OR;
        expect_val("or", SIG_RES, 32'hFFF0_0FFF);
        step();
        drive(32'd0, 32'h0000_1001, 32'h0000_0002, BSEL_REG, ALU_ADDCLR);
        expect_val("add_clr_lsb", SIG_RES, 32'h0000_1002);
        step();
        drive(32'd0, 32'h1234_5678, 32'hDEAD_BEEF, BSEL_ZERO, ALU_PASSB);
        expect_val("bsel_zero", SIG_RES, 32'd0);
        expect_val("eq_bsel_zero", SIG_EQ, 32'd0);
        step();
        drive(32'd0, 32'h1234_5678, 32'h1, BSEL_REG, 5'd12);
        expect_val("unassigned_op", SIG_RES, 32'd0);
        step();

        // -1 vs 1: signed less-than, unsigned greater-than.
        drive(32'd0, 32'hFFFF_FFFF, 32'd1, BSEL_REG, ALU_SLT);
        expect_val("eq_neg", SIG_EQ, 32'd0);
        expect_val("gt_neg", SIG_GT, 32'd0);
        expect_val("gtu_neg", SIG_GTU, 32'd1);
        expect_val("slt_neg", SIG_RES, 32'd1);
        step();
        alu_op = ALU_SLTU;
        expect_val("sltu_neg", SIG_RES, 32'd0);
        step();
        drive(32'd0, 32'd5, 32'd5, BSEL_REG, ALU_ADD);
        expect_val("eq_same", SIG_EQ, 32'd1);
        expect_val("gt_same", SIG_GT, 32'd0);
        expect_val("gtu_same", SIG_GTU, 32'd0);
        step();
        drive(32'd0, 32'd9, 32'hFFFF_FFFE, BSEL_REG, ALU_ADD);
        expect_val("gt_pos", SIG_GT, 32'd1);
        expect_val("gtu_pos", SIG_GTU, 32'd0);
        step();

        // Registered result, then reset winning over the update.
        drive(32'd0, 32'h0000_0100, 32'd0, BSEL_FOUR, ALU_ADD);
        expect_val("bsel_four", SIG_RES, 32'h0000_0104);
        step();
        expect_val("alu_out_reg", SIG_OUT, 32'h0000_0104);
        reset = 1'b1;
        step();
        expect_val("alu_out_reset", SIG_OUT, 32'd0);
        reset = 1'b0;
        step();
        expect_val("alu_out_resume", SIG_OUT, 32'h0000_0104);

`ifdef RV32M_EN
        drive(32'd0, 32'd7, 32'd0, BSEL_REG, ALU_DIV);
        expect_val("div_by_zero", SIG_RES, 32'hFFFF_FFFF);
        step();
        alu_op = ALU_REM;
        expect_val("rem_by_zero", SIG_RES, 32'd7);
        step();
        drive(32'd0, 32'h8000_0000, 32'hFFFF_FFFF, BSEL_REG, ALU_DIV);
        expect_val("div_ovf", SIG_RES, 32'h8000_0000);
        step();
        alu_op = ALU_REM;
        expect_val("rem_ovf", SIG_RES, 32'd0);
        step();
        drive(32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, BSEL_REG, ALU_MULHU);
        expect_val("mulhu", SIG_RES, 32'hFFFF_FFFE);
        step();
        alu_op = ALU_MULH;
        expect_val("mulh", SIG_RES, 32'd0);
        step();
        drive(32'd0, 32'hFFFF_FFF9, 32'd2, BSEL_REG, ALU_DIV);
        expect_val("div_signed", SIG_RES, 32'hFFFF_FFFD);
        step();
        alu_op = ALU_MUL;
        expect_val("mul", SIG_RES, 32'hFFFF_FFF2);
        step();
`else
        drive(32'd0, 32'd7, 32'd3, BSEL_REG, ALU_MUL);
        expect_val("mul_disabled", SIG_RES, 32'd0);
        step();
        alu_op = ALU_DIV;
        expect_val("div_disabled", SIG_RES, 32'd0);
        step();
`endif

        step();
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
